// File: rtl/lsu_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_port_arbiter_if
// Brief    : Lane-side and memory-side handshake bundle for lsu_port_arbiter.
// Revision : 1.0
// ============================================================================
interface lsu_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [2:0]        load_type0;
  logic [2:0]        load_type1;
  logic [1:0]        store_type0;
  logic [1:0]        store_type1;
  logic              done0;
  logic              done1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              err0;
  logic              err1;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  flush, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           load_type0, load_type1, store_type0, store_type1,
           mem_gnt, mem_rvalid, mem_rdata,
    output done0, done1, rdata0, rdata1, err0, err1, busy,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output flush, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
           load_type0, load_type1, store_type0, store_type1,
           mem_gnt, mem_rvalid, mem_rdata,
    input  done0, done1, rdata0, rdata1, err0, err1, busy,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/lsu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_port_arbiter
// Brief    : Serialises lane 0/1 loads and stores onto one data-memory port.
//            Macro LSU_ARB_MISALIGN_CHECK_EN enables misalignment faults.
// Revision : 1.0
// ============================================================================
module lsu_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

`ifdef LSU_ARB_MISALIGN_CHECK_EN
  localparam logic C_MISALIGN_EN = 1'b1;
`else
  localparam logic C_MISALIGN_EN = 1'b0;
`endif

  state_t            r_state;
  logic              r_sel;
  logic              r_we;
  logic [2:0]        r_lt;
  logic [1:0]        r_off;
  logic              r_skip;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic              w_sel;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [2:0]        w_lt;
  logic [1:0]        w_st;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_bad_type;
  logic              w_misalign;
  logic              w_skip;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_lane;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;

  // Lane 1 is only considered when lane 0 (the older instruction) is idle.
  assign w_sel   = ~bus.req0;
  assign w_we    = w_sel ? bus.we1         : bus.we0;
  assign w_addr  = w_sel ? bus.addr1       : bus.addr0;
  assign w_wdata = w_sel ? bus.wdata1      : bus.wdata0;
  assign w_lt    = w_sel ? bus.load_type1  : bus.load_type0;
  assign w_st    = w_sel ? bus.store_type1 : bus.store_type0;

  always_comb begin
    w_is_half    = 1'b0;
    w_is_word    = 1'b0;
    w_bad_type   = 1'b0;
    w_be         = 4'b1111;
    w_wdata_lane = w_wdata;
    if (w_we) begin
      case (w_st)
        2'b01: begin
          w_be         = 4'b0001 << w_addr[1:0];
          w_wdata_lane = {4{w_wdata[7:0]}};
        end
        2'b10: begin
          w_is_half    = 1'b1;
          w_be         = w_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata_lane = {2{w_wdata[15:0]}};
        end
        2'b11:   w_is_word  = 1'b1;
        default: w_bad_type = 1'b1;
      endcase
    end else begin
      case (w_lt)
        3'b001, 3'b010: begin
          w_is_half = 1'b0;
        end
        3'b011, 3'b100: w_is_half  = 1'b1;
        3'b101:         w_is_word  = 1'b1;
        default:        w_bad_type = 1'b1;
      endcase
    end
  end

  assign w_misalign = C_MISALIGN_EN &
                      ((w_is_half & w_addr[0]) | (w_is_word & (w_addr[1:0] != 2'b00)));
  assign w_skip     = w_bad_type | w_misalign;

  // Halfword lane selection deliberately ignores addr[0].
  assign w_byte = 8'(bus.mem_rdata >> {r_off, 3'b000});
  assign w_half = 16'(bus.mem_rdata >> {r_off[1], 4'b0000});

  always_comb begin
    case (r_lt)
      3'b001:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load_ext = {24'd0, w_byte};
      3'b011:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_we        <= 1'b0;
      r_lt        <= 3'd0;
      r_off       <= 2'd0;
      r_skip      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_rdata0    <= 32'd0;
      r_rdata1    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.flush && (bus.req0 || bus.req1)) begin
            r_sel       <= w_sel;
            r_we        <= w_we;
            r_lt        <= w_lt;
            r_off       <= w_addr[1:0];
            r_skip      <= w_skip;
            r_err       <= w_misalign;
            r_mem_req   <= ~w_skip;
            r_mem_we    <= w_we & ~w_skip;
            r_mem_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= w_wdata_lane;
            r_mem_be    <= w_be;
            if (w_sel) r_rdata1 <= 32'd0;
            else       r_rdata0 <= 32'd0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_skip) begin
            r_state <= bus.flush ? S_IDLE : S_DONE;
          end else if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            // A store granted alongside a flush has already been written.
            if (bus.flush) r_state <= r_we ? S_IDLE : S_DRAIN;
            else           r_state <= r_we ? S_DONE : S_WAIT;
          end else if (bus.flush) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            r_state <= bus.mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (bus.mem_rvalid) begin
            if (r_sel) r_rdata1 <= w_load_ext;
            else       r_rdata0 <= w_load_ext;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done0     = (r_state == S_DONE) & ~r_sel & ~bus.flush;
  assign bus.done1     = (r_state == S_DONE) &  r_sel & ~bus.flush;
  assign bus.err0      = bus.done0 & r_err;
  assign bus.err1      = bus.done1 & r_err;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_lsu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_port_arbiter
// Brief    : Directed-vector bench for lsu_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_lsu_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  lsu_port_arbiter_if #(.ADDR_W(32)) b ();

  lsu_port_arbiter #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b.flush = 1'b0;
    b.req0 = 1'b0; b.req1 = 1'b0; b.we0 = 1'b0; b.we1 = 1'b0;
    b.addr0 = 32'd0; b.addr1 = 32'd0; b.wdata0 = 32'd0; b.wdata1 = 32'd0;
    b.load_type0 = 3'd0; b.load_type1 = 3'd0; b.store_type0 = 2'd0; b.store_type1 = 2'd0;
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    nxt(); nxt(); mid();
    n_vec++; if (b.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0h exp 0", b.busy); end
    n_vec++; if ({b.done0, b.done1, b.err0, b.err1} !== 4'b0000) begin n_err++; $display("FAIL rst_done_err got %b exp 0000", {b.done0, b.done1, b.err0, b.err1}); end
    n_vec++; if ({b.mem_req, b.mem_we, b.mem_be} !== 6'd0) begin n_err++; $display("FAIL rst_mem_ctl got %b exp 000000", {b.mem_req, b.mem_we, b.mem_be}); end
    n_vec++; if ({b.rdata0, b.rdata1, b.mem_addr, b.mem_wdata} !== 128'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", {b.rdata0, b.rdata1, b.mem_addr, b.mem_wdata}); end
    nxt();
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_simultaneous();
    nxt();
    b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 32'h0000_1003; b.load_type0 = 3'b001;
    b.req1 = 1'b1; b.we1 = 1'b1; b.addr1 = 32'h0000_2000; b.wdata1 = 32'hDEAD_BEEF; b.store_type1 = 2'b11;
    b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h8000_0000;
    mid();
    n_vec++; if (b.mem_req !== 1'b0) begin n_err++; $display("FAIL sim_c0_mem_req got %0h exp 0", b.mem_req); end
    nxt(); mid();
    n_vec++; if ({b.mem_req, b.mem_we} !== 2'b10) begin n_err++; $display("FAIL sim_c1_req_we got %b exp 10", {b.mem_req, b.mem_we}); end
    n_vec++; if (b.mem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL sim_c1_addr got %h exp 00001000", b.mem_addr); end
    n_vec++; if (b.mem_be !== 4'b1111) begin n_err++; $display("FAIL sim_c1_be got %b exp 1111", b.mem_be); end
    nxt(); mid();
    n_vec++; if (b.done0 !== 1'b0) begin n_err++; $display("FAIL sim_c2_done0 got %0h exp 0", b.done0); end
    nxt(); mid();
    n_vec++; if ({b.done0, b.done1} !== 2'b10) begin n_err++; $display("FAIL sim_c3_done got %b exp 10", {b.done0, b.done1}); end
    n_vec++; if (b.rdata0 !== 32'hFFFF_FF80) begin n_err++; $display("FAIL sim_c3_rdata0 got %h exp ffffff80", b.rdata0); end
    nxt();
    b.req0 = 1'b0; b.load_type0 = 3'd0;
    mid();
    n_vec++; if (b.busy !== 1'b0) begin n_err++; $display("FAIL sim_c4_busy got %0h exp 0", b.busy); end
    nxt(); mid();
    n_vec++; if ({b.mem_req, b.mem_we, b.mem_be} !== 6'b111111) begin n_err++; $display("FAIL sim_c5_ctl got %b exp 111111", {b.mem_req, b.mem_we, b.mem_be}); end
    n_vec++; if ({b.mem_addr, b.mem_wdata} !== 64'h0000_2000_DEAD_BEEF) begin n_err++; $display("FAIL sim_c5_addr_data got %h exp 00002000deadbeef", {b.mem_addr, b.mem_wdata}); end
    nxt(); mid();
    n_vec++; if ({b.done0, b.done1} !== 2'b01) begin n_err++; $display("FAIL sim_c6_done got %b exp 01", {b.done0, b.done1}); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_lhu();
    nxt();
    b.req0 = 1'b1; b.addr0 = 32'h0000_0002; b.load_type0 = 3'b100;
    b.mem_gnt = 1'b1; b.mem_rvalid = 1'b1; b.mem_rdata = 32'hABCD_1234;
    nxt(); nxt(); mid();
    n_vec++; if (b.done0 !== 1'b0) begin n_err++; $display("FAIL lhu_c2_done0 got %0h exp 0", b.done0); end
    nxt(); mid();
    n_vec++; if (b.done0 !== 1'b1) begin n_err++; $display("FAIL lhu_c3_done0 got %0h exp 1", b.done0); end
    n_vec++; if (b.rdata0 !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_rdata0 got %h exp 0000abcd", b.rdata0); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_sh();
    nxt();
    b.req1 = 1'b1; b.we1 = 1'b1; b.addr1 = 32'h0000_0006; b.wdata1 = 32'hFFFF_1234; b.store_type1 = 2'b10;
    nxt(); mid();
    n_vec++; if (b.mem_addr !== 32'h0000_0004) begin n_err++; $display("FAIL sh_addr got %h exp 00000004", b.mem_addr); end
    n_vec++; if (b.mem_be !== 4'b1100) begin n_err++; $display("FAIL sh_be got %b exp 1100", b.mem_be); end
    n_vec++; if (b.mem_wdata !== 32'h1234_1234) begin n_err++; $display("FAIL sh_wdata got %h exp 12341234", b.mem_wdata); end
    nxt();
    b.mem_gnt = 1'b1;
    nxt();
    b.mem_gnt = 1'b0;
    mid();
    n_vec++; if (b.done1 !== 1'b1) begin n_err++; $display("FAIL sh_done1 got %0h exp 1", b.done1); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_grant_stall();
    nxt();
    b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h0000_0011; b.wdata0 = 32'h0000_00A5; b.store_type0 = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      nxt(); mid();
      n_vec++; if ({b.mem_req, b.mem_we, b.mem_be, b.done0} !== 7'b1100100) begin n_err++; $display("FAIL stall_c%0d_ctl got %b exp 1100100", k, {b.mem_req, b.mem_we, b.mem_be, b.done0}); end
      n_vec++; if ({b.mem_addr, b.mem_wdata} !== 64'h0000_0010_A5A5_A5A5) begin n_err++; $display("FAIL stall_c%0d_fields got %h exp 00000010a5a5a5a5", k, {b.mem_addr, b.mem_wdata}); end
    end
    nxt();
    b.mem_gnt = 1'b1;
    mid();
    n_vec++; if ({b.mem_req, b.done0} !== 2'b10) begin n_err++; $display("FAIL stall_gnt_cycle got %b exp 10", {b.mem_req, b.done0}); end
    nxt();
    b.mem_gnt = 1'b0;
    mid();
    n_vec++; if ({b.mem_req, b.done0} !== 2'b01) begin n_err++; $display("FAIL stall_done0 got %b exp 01", {b.mem_req, b.done0}); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_flush_load();
    nxt();
    b.req0 = 1'b1; b.addr0 = 32'h0000_0100; b.load_type0 = 3'b101; b.mem_gnt = 1'b1;
    nxt();
    nxt();
    b.mem_gnt = 1'b0; b.flush = 1'b1; b.req0 = 1'b0; b.load_type0 = 3'd0;
    mid();
    n_vec++; if ({b.busy, b.done0} !== 2'b10) begin n_err++; $display("FAIL flw_c2 got %b exp 10", {b.busy, b.done0}); end
    nxt();
    b.flush = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      mid();
      n_vec++; if ({b.busy, b.done0, b.done1} !== 3'b100) begin n_err++; $display("FAIL flw_c%0d_drain got %b exp 100", k, {b.busy, b.done0, b.done1}); end
      nxt();
    end
    b.mem_rvalid = 1'b1; b.mem_rdata = 32'h5555_5555;
    mid();
    n_vec++; if ({b.busy, b.done0} !== 2'b10) begin n_err++; $display("FAIL flw_c5_rvalid got %b exp 10", {b.busy, b.done0}); end
    nxt();
    b.mem_rvalid = 1'b0;
    b.req1 = 1'b1; b.addr1 = 32'h0000_0300; b.load_type1 = 3'b101; b.mem_gnt = 1'b1;
    mid();
    n_vec++; if ({b.busy, b.done0} !== 2'b00) begin n_err++; $display("FAIL flw_c6_idle got %b exp 00", {b.busy, b.done0}); end
    nxt(); mid();
    n_vec++; if ({b.mem_req, b.mem_addr} !== {1'b1, 32'h0000_0300}) begin n_err++; $display("FAIL flw_next_req got %h exp 100000300", {b.mem_req, b.mem_addr}); end
    nxt();
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'h1122_3344;
    nxt();
    b.mem_rvalid = 1'b0;
    mid();
    n_vec++; if (b.done1 !== 1'b1) begin n_err++; $display("FAIL flw_next_done1 got %0h exp 1", b.done1); end
    n_vec++; if (b.rdata1 !== 32'h1122_3344) begin n_err++; $display("FAIL flw_next_rdata1 got %h exp 11223344", b.rdata1); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_flush_done();
    nxt();
    b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 32'h0000_0040; b.wdata0 = 32'h1; b.store_type0 = 2'b11; b.mem_gnt = 1'b1;
    nxt();
    nxt();
    b.flush = 1'b1; b.mem_gnt = 1'b0;
    mid();
    n_vec++; if ({b.busy, b.done0} !== 2'b10) begin n_err++; $display("FAIL fld_suppress got %b exp 10", {b.busy, b.done0}); end
    nxt();
    idle_inputs();
    mid();
    n_vec++; if ({b.busy, b.done0} !== 2'b00) begin n_err++; $display("FAIL fld_after got %b exp 00", {b.busy, b.done0}); end
    nxt();
  endtask

  task automatic test_invalid_type();
    logic got_done;
    logic saw_req;
    got_done = 1'b0;
    saw_req  = 1'b0;
    nxt();
    b.req0 = 1'b1; b.addr0 = 32'h0000_0000; b.load_type0 = 3'b000; b.mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      if (b.mem_req) saw_req = 1'b1;
      if (b.done0) begin
        got_done = 1'b1;
        n_vec++; if ({b.rdata0, b.err0} !== 33'd0) begin n_err++; $display("FAIL inv_rdata_err got %h exp 0", {b.rdata0, b.err0}); end
        break;
      end
      nxt();
    end
    n_vec++; if (got_done !== 1'b1) begin n_err++; $display("FAIL inv_done_timeout got %0h exp 1", got_done); end
    n_vec++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL inv_mem_req got %0h exp 0", saw_req); end
    nxt();
    idle_inputs();
    nxt();
  endtask

  task automatic test_misalign();
    nxt();
    b.req0 = 1'b1; b.addr0 = 32'h0000_0001; b.load_type0 = 3'b101; b.mem_gnt = 1'b1;
`ifdef LSU_ARB_MISALIGN_CHECK_EN
    nxt(); mid();
    n_vec++; if ({b.mem_req, b.done0} !== 2'b00) begin n_err++; $display("FAIL mis_c1 got %b exp 00", {b.mem_req, b.done0}); end
    nxt(); mid();
    n_vec++; if ({b.done0, b.err0, b.mem_req} !== 3'b110) begin n_err++; $display("FAIL mis_c2 got %b exp 110", {b.done0, b.err0, b.mem_req}); end
    n_vec++; if (b.rdata0 !== 32'd0) begin n_err++; $display("FAIL mis_rdata0 got %h exp 0", b.rdata0); end
`else
    nxt(); mid();
    n_vec++; if ({b.mem_req, b.mem_be, b.mem_addr} !== {1'b1, 4'b1111, 32'h0}) begin n_err++; $display("FAIL mis_off_req got %h exp 1f00000000", {b.mem_req, b.mem_be, b.mem_addr}); end
    nxt();
    b.mem_gnt = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'hCAFE_F00D;
    nxt();
    b.mem_rvalid = 1'b0;
    mid();
    n_vec++; if ({b.done0, b.err0} !== 2'b10) begin n_err++; $display("FAIL mis_off_done got %b exp 10", {b.done0, b.err0}); end
    n_vec++; if (b.rdata0 !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mis_off_rdata0 got %h exp cafef00d", b.rdata0); end
`endif
    nxt();
    idle_inputs();
    nxt();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_simultaneous();
    test_lhu();
    test_sh();
    test_grant_stall();
    test_flush_load();
    test_flush_done();
    test_invalid_type();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
